// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: PC geometry and the per-slot prediction record
package branch_resolver_pkg;
  localparam int PC_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] PC_INC = 32'd4;
  typedef struct packed {
    logic                valid;
    logic                ptaken;
    logic [PC_WIDTH-1:0] ptarget;
  } slot_t;
endpackage

// File: rtl/branch_meta_slot.sv
// branch_meta_slot: one pipeline slot of prediction metadata with bubble/hold/load
module branch_meta_slot
  import branch_resolver_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);
  // bubble outranks hold so a mispredict can squash a stalled slot
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (bubble) q.valid <= 1'b0;
    else if (!hold) q <= d;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: carries predictions to EX, flags mispredicts, counts branches
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  PC_IF,
  input  logic                 BHT_hit,
  input  logic                 Predict_taken,
  input  logic [PC_WIDTH-1:0]  Predict_target,
  input  logic                 Stall,
  input  logic                 Flush_ID,
  input  logic                 ID_EX_Branch,
  input  logic                 Branch_taken,
  input  logic [PC_WIDTH-1:0]  Branch_target,
  input  logic [PC_WIDTH-1:0]  PC_EX,
  output logic                 Mispredict,
  output logic [PC_WIDTH-1:0]  Redirect_PC,
  output logic [CNT_WIDTH-1:0] Branch_count,
  output logic [CNT_WIDTH-1:0] Mispredict_count
);
  slot_t capture, ifid, idex;
  logic  eval, wrong_dir, wrong_tgt, unused_pc_if;
  assign unused_pc_if = ^PC_IF;
  assign capture = '{valid: 1'b1, ptaken: BHT_hit & Predict_taken, ptarget: Predict_target};
  branch_meta_slot u_ifid (
    .clk    (clk),
    .reset  (reset),
    .hold   (Stall),
    .bubble (Mispredict | (!Stall & Flush_ID)),
    .d      (capture),
    .q      (ifid)
  );
  branch_meta_slot u_idex (
    .clk    (clk),
    .reset  (reset),
    .hold   (1'b0),
    .bubble (Mispredict | Stall),
    .d      (ifid),
    .q      (idex)
  );
  assign eval        = ID_EX_Branch & idex.valid;
  assign wrong_dir   = idex.ptaken ^ Branch_taken;
  assign wrong_tgt   = idex.ptaken & Branch_taken & (idex.ptarget != Branch_target);
  assign Mispredict  = eval & (wrong_dir | wrong_tgt);
  assign Redirect_PC = !Mispredict ? '0
                     : (idex.ptaken & !Branch_taken) ? PC_EX + PC_INC
                     : Branch_target;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      Branch_count     <= '0;
      Mispredict_count <= '0;
    end else begin
      if (eval && !(&Branch_count)) Branch_count <= Branch_count + CNT_WIDTH'(1);
      if (Mispredict && !(&Mispredict_count)) Mispredict_count <= Mispredict_count + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors for branch_resolver with hand-computed expectations
module tb_branch_resolver;
  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] PC_IF = '0, Predict_target = '0, Branch_target = '0, PC_EX = '0;
  logic        BHT_hit = 1'b0, Predict_taken = 1'b0, Stall = 1'b0, Flush_ID = 1'b0;
  logic        ID_EX_Branch = 1'b0, Branch_taken = 1'b0;
  logic        Mispredict;
  logic [31:0] Redirect_PC;
  logic [3:0]  Branch_count, Mispredict_count;
  int checks = 0, failures = 0;
  branch_resolver #(.CNT_WIDTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .PC_IF            (PC_IF),
    .BHT_hit          (BHT_hit),
    .Predict_taken    (Predict_taken),
    .Predict_target   (Predict_target),
    .Stall            (Stall),
    .Flush_ID         (Flush_ID),
    .ID_EX_Branch     (ID_EX_Branch),
    .Branch_taken     (Branch_taken),
    .Branch_target    (Branch_target),
    .PC_EX            (PC_EX),
    .Mispredict       (Mispredict),
    .Redirect_PC      (Redirect_PC),
    .Branch_count     (Branch_count),
    .Mispredict_count (Mispredict_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cnt(input string tag, input logic [3:0] b, input logic [3:0] m);
    chk({tag, " branch_count"}, 32'(Branch_count), 32'(b));
    chk({tag, " mispredict_count"}, 32'(Mispredict_count), 32'(m));
  endtask
  // fetch a predicted instruction, advance it to EX, present the resolved outcome and check
  task automatic run_branch(input string tag, input logic hit, input logic ptk, input logic [31:0] ptgt,
                            input logic tk, input logic [31:0] tgt, input logic [31:0] pc,
                            input logic exp_mis, input logic [31:0] exp_rd);
    BHT_hit = hit; Predict_taken = ptk; Predict_target = ptgt; PC_IF = pc;
    step();
    BHT_hit = 1'b0; Predict_taken = 1'b0; Predict_target = '0; PC_IF = pc + 4;
    step();
    ID_EX_Branch = 1'b1; Branch_taken = tk; Branch_target = tgt; PC_EX = pc;
    #1;
    if (tag != "") begin
      chk({tag, " mispredict"}, 32'(Mispredict), 32'(exp_mis));
      chk({tag, " redirect"}, Redirect_PC, exp_rd);
    end
    step();
    ID_EX_Branch = 1'b0; Branch_taken = 1'b0;
  endtask
  initial begin
    #1;
    ID_EX_Branch = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h100;
    #1;
    chk("in-reset mispredict", 32'(Mispredict), 0);
    chk("in-reset redirect", Redirect_PC, 0);
    chk_cnt("in-reset", 0, 0);
    ID_EX_Branch = 1'b0; Branch_taken = 1'b0; Branch_target = '0;
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle mispredict", 32'(Mispredict), 0);
    end
    chk_cnt("idle", 0, 0);
    run_branch("taken->not", 1, 1, 32'h80, 0, 32'h80, 32'h40, 1, 32'h44);
    chk_cnt("after taken->not", 1, 1);
    ID_EX_Branch = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h200;
    #1;
    chk("squashed idex", 32'(Mispredict), 0);
    step();
    chk("squashed ifid", 32'(Mispredict), 0);
    chk_cnt("bubbles", 1, 1);
    ID_EX_Branch = 1'b0; Branch_taken = 1'b0;
    run_branch("miss->taken", 0, 1, 32'h80, 1, 32'h100, 32'h50, 1, 32'h100);
    run_branch("wrong target", 1, 1, 32'h80, 1, 32'h90, 32'h60, 1, 32'h90);
    run_branch("right target", 1, 1, 32'h80, 1, 32'h80, 32'h60, 0, 32'h0);
    chk_cnt("after right target", 4, 3);
    run_branch("not->not", 1, 0, 32'h80, 0, 32'h80, 32'h70, 0, 32'h0);
    chk_cnt("after not->not", 5, 3);
    BHT_hit = 1'b1; Predict_taken = 1'b1; Predict_target = 32'h80; PC_IF = 32'h60;
    step();
    BHT_hit = 1'b0; Predict_taken = 1'b0; Predict_target = '0; Stall = 1'b1;
    step();
    Stall = 1'b0; ID_EX_Branch = 1'b1; Branch_taken = 1'b1; Branch_target = 32'h80;
    #1;
    chk("stall bubble", 32'(Mispredict), 0);
    step();
    chk_cnt("stall bubble", 5, 3);
    Branch_taken = 1'b0; PC_EX = 32'h60; Flush_ID = 1'b1;
    #1;
    chk("post-stall mispredict", 32'(Mispredict), 1);
    chk("post-stall redirect", Redirect_PC, 32'h64);
    step();
    Flush_ID = 1'b0; Branch_taken = 1'b1; Branch_target = 32'h300;
    #1;
    chk("flush+mis idex", 32'(Mispredict), 0);
    chk_cnt("flush+mis", 6, 4);
    step();
    chk("flush+mis ifid", 32'(Mispredict), 0);
    chk_cnt("flush+mis later", 6, 4);
    ID_EX_Branch = 1'b0; Branch_taken = 1'b0;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    chk_cnt("reset pulse", 0, 0);
    for (int i = 0; i < 15; i++) run_branch("", 1, 1, 32'h80, 1, 32'h80, 32'h400, 0, 0);
    chk_cnt("15 correct", 15, 0);
    for (int i = 0; i < 2; i++) run_branch("", 1, 1, 32'h80, 1, 32'h80, 32'h400, 0, 0);
    chk_cnt("17 correct", 15, 0);
    for (int i = 0; i < 16; i++) run_branch("", 0, 0, 32'h0, 1, 32'h500, 32'h400, 1, 32'h500);
    chk_cnt("16 mispredicts", 15, 15);
    BHT_hit = 1'b1; Predict_taken = 1'b1; Predict_target = 32'h80; PC_IF = 32'h40;
    step();
    BHT_hit = 1'b0; Predict_taken = 1'b0; Predict_target = '0;
    step();
    ID_EX_Branch = 1'b1; Branch_taken = 1'b0; PC_EX = 32'h40;
    #1;
    chk("pre-reset mispredict", 32'(Mispredict), 1);
    #1 reset = 1'b0;
    #1;
    chk("async reset mispredict", 32'(Mispredict), 0);
    chk("async reset redirect", Redirect_PC, 0);
    chk_cnt("async reset", 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
